// File: rtl/addr_gen_pkg.sv
// Shared types and helpers for the scaled/mirrored frame-buffer address generator.
// Contents: default geometry, view_mode_t (latched mirror/flip pair), step_calc() constant function.
// No ports; imported by scaled_mirror_addr_gen.
package addr_gen_pkg;

   localparam int DEF_SRC_W   = 320;
   localparam int DEF_SRC_H   = 240;
   localparam int DEF_DST_W   = 1024;
   localparam int DEF_DST_H   = 768;
   localparam int DEF_H_CNT_W = 11;
   localparam int DEF_V_CNT_W = 10;
   localparam int DEF_ADDR_W  = 17;
   localparam int DEF_FRAC_W  = 16;

   typedef struct packed {
      logic mirror;
      logic flip;
   } view_mode_t;

   // Fixed-point source step per destination pixel: floor(src * 2**frac / dst).
   function automatic int unsigned step_calc(input int unsigned src,
                                             input int unsigned dst,
                                             input int unsigned frac);
      longint unsigned num;
      num = 64'(src) << frac;
      return 32'(num / 64'(dst));
   endfunction

endpackage

// File: rtl/axis_dda.sv
// Single-axis DDA: accumulates STEP per advance, reports the integer source position.
// Ports: clk_in/rst_in (async active-high), restart (position 0 now), advance (step after this sample),
//        pos (integer part for the current sample), carry (integer part increments on this advance).
module axis_dda #(
   parameter int unsigned STEP   = 20480,
   parameter int          FRAC_W = 16,
   parameter int          INT_W  = 9
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             restart,
   input  logic             advance,
   output logic [INT_W-1:0] pos,
   output logic             carry
);

   localparam int ACC_W = INT_W + FRAC_W;
   localparam logic [ACC_W-1:0] STEP_V = ACC_W'(STEP);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_sum;

   assign acc_sum = acc + STEP_V;

   // acc always holds the value for the *next* sample, so a restart must force
   // the current position to zero combinationally.
   assign pos   = restart ? '0 : acc[ACC_W-1:FRAC_W];

   // Upscale only (STEP <= 2**FRAC_W), so the integer part moves by at most one.
   assign carry = advance && !restart &&
                  (acc_sum[ACC_W-1:FRAC_W] != acc[ACC_W-1:FRAC_W]);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         acc <= '0;
      end else if (restart) begin
         acc <= advance ? STEP_V : '0;
      end else if (advance) begin
         acc <= acc_sum;
      end
   end

endmodule

// File: rtl/scaled_mirror_addr_gen.sv
// Maps timing counters to an upscaled, optionally mirrored/flipped frame-buffer read address.
// Ports: clk_in/rst_in (async active-high); hcount_in/vcount_in; mirror_in/flip_in (latched at frame start);
//        pixel_addr_out/addr_valid_out two register stages after the counters; sync_err_out sticky flag.
// Optional hcount discontinuity detection is built when SCALED_ADDR_SYNC_CHECK_EN is defined.
module scaled_mirror_addr_gen
   import addr_gen_pkg::*;
#(
   parameter int SRC_W   = DEF_SRC_W,
   parameter int SRC_H   = DEF_SRC_H,
   parameter int DST_W   = DEF_DST_W,
   parameter int DST_H   = DEF_DST_H,
   parameter int H_CNT_W = DEF_H_CNT_W,
   parameter int V_CNT_W = DEF_V_CNT_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int FRAC_W  = DEF_FRAC_W
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic [H_CNT_W-1:0] hcount_in,
   input  logic [V_CNT_W-1:0] vcount_in,
   input  logic               mirror_in,
   input  logic               flip_in,
   output logic [ADDR_W-1:0]  pixel_addr_out,
   output logic               addr_valid_out,
   output logic               sync_err_out
);

   localparam int unsigned STEP_X = step_calc(SRC_W, DST_W, FRAC_W);
   localparam int unsigned STEP_Y = step_calc(SRC_H, DST_H, FRAC_W);
   // The accumulator reaches DST*STEP (<= SRC*2**FRAC_W) after the last active step.
   localparam int XI_W = $clog2(SRC_W + 1);
   localparam int YI_W = $clog2(SRC_H + 1);

   localparam logic [H_CNT_W:0]   H_ACT       = (H_CNT_W + 1)'(DST_W);
   localparam logic [V_CNT_W:0]   V_ACT       = (V_CNT_W + 1)'(DST_H);
   localparam logic [H_CNT_W-1:0] H_END       = H_CNT_W'(DST_W - 1);
   localparam logic [ADDR_W-1:0]  A_SRC_W     = ADDR_W'(SRC_W);
   localparam logic [ADDR_W-1:0]  A_LAST_COL  = ADDR_W'(SRC_W - 1);
   localparam logic [ADDR_W-1:0]  A_FLIP_BASE = ADDR_W'((SRC_H - 1) * SRC_W);

   if (SRC_W > DST_W || SRC_H > DST_H) begin : g_geom_chk
      $fatal(1, "scaled_mirror_addr_gen: only upscale or 1:1 geometry is supported");
   end
   if ((64'd1 << ADDR_W) < 64'(SRC_W * SRC_H)) begin : g_addr_chk
      $fatal(1, "scaled_mirror_addr_gen: ADDR_W too small for SRC_W*SRC_H");
   end

   logic              frame_start;
   logic              x_restart;
   logic              h_active;
   logic              v_active;
   logic              line_end;
   logic              h_bad;
   view_mode_t        mode_in;
   view_mode_t        mode_q;
   view_mode_t        mode_cur;
   logic              locked_q;
   logic              lock_cur;
   logic [XI_W-1:0]   x_pos;
   logic              x_carry;
   logic [YI_W-1:0]   y_pos;
   logic              y_carry;
   logic [ADDR_W-1:0] row_init;
   logic [ADDR_W-1:0] row_base_q;
   logic [ADDR_W-1:0] row_base_cur;
   logic [ADDR_W-1:0] col_cur;
   logic [ADDR_W-1:0] col_s1;
   logic [ADDR_W-1:0] row_s1;
   logic              valid_s1;

   assign frame_start = (hcount_in == '0) && (vcount_in == '0);
   assign x_restart   = (hcount_in == '0);
   assign h_active    = {1'b0, hcount_in} < H_ACT;
   assign v_active    = {1'b0, vcount_in} < V_ACT;
   assign line_end    = (hcount_in == H_END) && v_active;

   // At the frame-start sample the live inputs take effect immediately;
   // everywhere else the latched copy is used so a frame never tears.
   assign mode_in  = {mirror_in, flip_in};
   assign mode_cur = frame_start ? mode_in : mode_q;
   assign lock_cur = (frame_start | locked_q) & ~h_bad;

   assign row_init     = mode_cur.flip ? A_FLIP_BASE : '0;
   assign row_base_cur = frame_start ? row_init : row_base_q;
   assign col_cur      = mode_cur.mirror ? (A_LAST_COL - ADDR_W'(x_pos)) : ADDR_W'(x_pos);

   axis_dda #(
      .STEP   (STEP_X),
      .FRAC_W (FRAC_W),
      .INT_W  (XI_W)
   ) u_x_dda (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .restart (x_restart),
      .advance (h_active),
      .pos     (x_pos),
      .carry   (x_carry)
   );

   axis_dda #(
      .STEP   (STEP_Y),
      .FRAC_W (FRAC_W),
      .INT_W  (YI_W)
   ) u_y_dda (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .restart (frame_start),
      .advance (line_end),
      .pos     (y_pos),
      .carry   (y_carry)
   );

   // Rows come from the carry-driven row base; columns need no carry.
   logic unused_dda;
   assign unused_dda = &{1'b0, x_carry, y_pos};

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         mode_q         <= '0;
         locked_q       <= 1'b0;
         row_base_q     <= '0;
         col_s1         <= '0;
         row_s1         <= '0;
         valid_s1       <= 1'b0;
         pixel_addr_out <= '0;
         addr_valid_out <= 1'b0;
      end else begin
         if (frame_start) begin
            mode_q <= mode_in;
         end
         locked_q <= lock_cur;

         // Row base tracks row*SRC_W (or its flipped image) for the next line.
         if (frame_start) begin
            row_base_q <= row_init;
         end else if (y_carry) begin
            row_base_q <= mode_q.flip ? (row_base_q - A_SRC_W) : (row_base_q + A_SRC_W);
         end

         col_s1   <= col_cur;
         row_s1   <= row_base_cur;
         valid_s1 <= h_active & v_active & lock_cur;

         addr_valid_out <= valid_s1;
         if (valid_s1) begin
            pixel_addr_out <= row_s1 + col_s1;
         end
      end
   end

`ifdef SCALED_ADDR_SYNC_CHECK_EN
   logic [H_CNT_W-1:0] prev_h;
   logic               prev_seen;
   logic               sync_err_q;

   // prev_seen keeps the first sample after reset from being judged against a stale value.
   assign h_bad = prev_seen && (hcount_in != '0) && (hcount_in != prev_h + H_CNT_W'(1));

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         prev_h     <= '0;
         prev_seen  <= 1'b0;
         sync_err_q <= 1'b0;
      end else begin
         prev_h    <= hcount_in;
         prev_seen <= 1'b1;
         if (h_bad) begin
            sync_err_q <= 1'b1;
         end
      end
   end

   assign sync_err_out = sync_err_q;
`else
   assign h_bad        = 1'b0;
   assign sync_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_scaled_mirror_addr_gen.sv
// Scoreboard bench for scaled_mirror_addr_gen: a formula-based model predicts valid/address
// two cycles after each counter sample and the sticky sync error one cycle after it.
// Geometry is shrunk (non-integer step ratio) so that several full frames fit in a short run.
module tb_scaled_mirror_addr_gen;

   localparam int SRC_W   = 20;
   localparam int SRC_H   = 15;
   localparam int DST_W   = 70;
   localparam int DST_H   = 50;
   localparam int H_TOT   = 80;
   localparam int V_TOT   = 54;
   localparam int H_CNT_W = 11;
   localparam int V_CNT_W = 10;
   localparam int ADDR_W  = 17;
   localparam int FRAC_W  = 16;
`ifdef SCALED_ADDR_SYNC_CHECK_EN
   localparam bit SYNC_EN = 1'b1;
`else
   localparam bit SYNC_EN = 1'b0;
`endif

   localparam longint STEP_X = (longint'(SRC_W) << FRAC_W) / DST_W;
   localparam longint STEP_Y = (longint'(SRC_H) << FRAC_W) / DST_H;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [H_CNT_W-1:0] hcount = '0;
   logic [V_CNT_W-1:0] vcount = '0;
   logic               mirror = 1'b0;
   logic               flip = 1'b0;
   logic [ADDR_W-1:0]  pixel_addr;
   logic               addr_valid;
   logic               sync_err;

   scaled_mirror_addr_gen #(
      .SRC_W   (SRC_W),
      .SRC_H   (SRC_H),
      .DST_W   (DST_W),
      .DST_H   (DST_H),
      .H_CNT_W (H_CNT_W),
      .V_CNT_W (V_CNT_W),
      .ADDR_W  (ADDR_W),
      .FRAC_W  (FRAC_W)
   ) dut (
      .clk_in         (clk),
      .rst_in         (rst),
      .hcount_in      (hcount),
      .vcount_in      (vcount),
      .mirror_in      (mirror),
      .flip_in        (flip),
      .pixel_addr_out (pixel_addr),
      .addr_valid_out (addr_valid),
      .sync_err_out   (sync_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int                due;
      logic              vld;
      logic [ADDR_W-1:0] addr;
      bit                chk_addr;
   } exp_t;

   typedef struct {
      int   due;
      logic err;
   } err_t;

   exp_t exp_q[$];
   err_t err_q[$];
   int   checks = 0;
   int   errors = 0;

   // Model state
   bit m_locked, m_mir, m_flp, m_sync_err, m_prev_seen, m_x_broken, m_unknown;
   int m_prev_h;
   int m_last;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic int ref_addr(input int h, input int v, input bit mir, input bit flp);
      longint sx, sy, col, row;
      sx  = (longint'(h) * STEP_X) >> FRAC_W;
      sy  = (longint'(v) * STEP_Y) >> FRAC_W;
      col = mir ? (SRC_W - 1 - sx) : sx;
      row = flp ? (SRC_H - 1 - sy) : sy;
      return int'(row * SRC_W + col);
   endfunction

   task automatic model_reset();
      m_locked    = 0;
      m_mir       = 0;
      m_flp       = 0;
      m_sync_err  = 0;
      m_prev_seen = 0;
      m_x_broken  = 1;
      m_unknown   = 0;
      m_prev_h    = 0;
      m_last      = 0;
   endtask

   // Drives one counter sample, predicts its outcome, then advances one clock.
   task automatic issue(input int h, input int v);
      bit   fs, bad, vld;
      exp_t e;
      err_t r;
      hcount = H_CNT_W'(h);
      vcount = V_CNT_W'(v);
      if ($urandom_range(0, 149) == 0) mirror = ~mirror;
      if ($urandom_range(0, 149) == 0) flip = ~flip;

      fs  = (h == 0) && (v == 0);
      bad = SYNC_EN && m_prev_seen && (h != 0) && (h != ((m_prev_h + 1) % (1 << H_CNT_W)));
      // A counter jump leaves the incremental x position unspecified until the next line start.
      if (h == 0) m_x_broken = 0;
      else if (!m_prev_seen || h != m_prev_h + 1) m_x_broken = 1;
      m_prev_h    = h;
      m_prev_seen = 1;

      if (fs) begin
         m_mir    = mirror;
         m_flp    = flip;
         m_locked = 1;
      end
      if (bad) begin
         m_locked   = 0;
         m_sync_err = 1;
      end
      vld = (h < DST_W) && (v < DST_H) && m_locked;
      if (vld) begin
         m_last    = ref_addr(h, v, m_mir, m_flp);
         m_unknown = m_x_broken;
      end

      e.due      = cyc + 2;
      e.vld      = vld;
      e.addr     = ADDR_W'(m_last);
      e.chk_addr = !m_unknown;
      exp_q.push_back(e);
      r.due = cyc + 1;
      r.err = m_sync_err;
      err_q.push_back(r);

      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("reset_addr", pixel_addr, 0);
      check("reset_valid", addr_valid, 0);
      check("reset_sync_err", sync_err, 0);
      exp_q.delete();
      err_q.delete();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic run_frame(input int start_v, input int start_h, input bit m, input bit f,
                            input int rst_line, input int jump_line);
      mirror = m;
      flip   = f;
      for (int v = start_v; v < V_TOT; v++) begin
         for (int h = (v == start_v) ? start_h : 0; h < H_TOT; h++) begin
            if (v == rst_line && h == 25) do_reset();
            if (v == jump_line && h == 51) h = 60;
            if (v == V_TOT / 2 && h == 0) begin
               mirror = ~mirror;
               flip   = ~flip;
            end
            issue(h, v);
         end
      end
   endtask

   // Monitor: compares whatever the DUT presents against the queued predictions.
   exp_t mon_e;
   err_t mon_r;
   always @(negedge clk) begin
      if (!rst) begin
         while (err_q.size() > 0 && err_q[0].due <= cyc) begin
            mon_r = err_q.pop_front();
            check("sync_err", sync_err, mon_r.err);
         end
         while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_e = exp_q.pop_front();
            check("addr_valid", addr_valid, mon_e.vld);
            if (mon_e.chk_addr) check("pixel_addr", pixel_addr, mon_e.addr);
            if (addr_valid) check("addr_range", (pixel_addr < SRC_W * SRC_H) ? 1 : 0, 1);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      do_reset();
      run_frame(10, 30, 1'b0, 1'b0, -1, -1);   // mid-frame start: nothing valid before lock
      run_frame(0, 0, 1'b0, 1'b0, -1, -1);
      run_frame(0, 0, 1'b1, 1'b0, -1, -1);
      run_frame(0, 0, 1'b0, 1'b1, -1, -1);
      run_frame(0, 0, 1'b1, 1'b1, 30, -1);     // reset in the middle of the frame
      run_frame(0, 0, 1'b0, 1'b0, -1, -1);
      run_frame(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 5);  // hcount 50 -> 60
      run_frame(0, 0, 1'b1, 1'b0, -1, -1);
      repeat (4) @(posedge clk);
      #1;
      check("queue_drained", exp_q.size() + err_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
